// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV32/RV64 immediate generator with valid/ready flow control.
// The IMMGEN_STATS_EN macro adds stat_ill_cnt, a saturating count of accepted illegal opcodes.
module imm_gen_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [31:0]     out_instr
`ifdef IMMGEN_STATS_EN
    ,
    output logic [15:0]     stat_ill_cnt
`endif
);
    localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3;
    localparam logic [2:0] F_U = 3'd4, F_J = 3'd5, F_ILL = 3'd7;

    logic [6:0]      op;
    logic            is_shift;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;

    assign op       = in_instr[6:0];
    assign is_shift = in_instr[13:12] == 2'b01;
    assign imm_i    = XLEN'($signed(in_instr[31:20]));
    assign imm_s    = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
    assign imm_b    = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
    assign imm_u    = XLEN'($signed({in_instr[31:12], 12'b0}));
    assign imm_j    = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
    assign shamt    = (XLEN == 64) ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);

    // classify the opcode and select the matching immediate
    always_comb begin
        dec_fmt = F_ILL;
        dec_imm = '0;
        case (op)
            7'b0000011, 7'b1100111: begin dec_fmt = F_I; dec_imm = imm_i; end
            7'b0010011: begin dec_fmt = F_I; dec_imm = is_shift ? shamt : imm_i; end
            7'b0011011: if (XLEN == 64) begin
                dec_fmt = F_I;
                dec_imm = is_shift ? XLEN'(in_instr[24:20]) : imm_i;
            end
            7'b0100011: begin dec_fmt = F_S; dec_imm = imm_s; end
            7'b1100011: begin dec_fmt = F_B; dec_imm = imm_b; end
            7'b0110111, 7'b0010111: begin dec_fmt = F_U; dec_imm = imm_u; end
            7'b1101111: begin dec_fmt = F_J; dec_imm = imm_j; end
            7'b0110011: dec_fmt = F_R;
            7'b0111011: dec_fmt = (XLEN == 64) ? F_R : F_ILL;
            default: dec_fmt = F_ILL;
        endcase
    end

    logic [STAGES-1:0] v_q, ld, nv;
    logic [31:0]       instr_q [STAGES];
    logic [XLEN-1:0]   imm_q   [STAGES];
    logic [2:0]        fmt_q   [STAGES];
    logic [31:0]       instr_d [STAGES];
    logic [XLEN-1:0]   imm_d   [STAGES];
    logic [2:0]        fmt_d   [STAGES];

    // a stage may load when out_ready is high or any stage from it to the output is empty
    always_comb begin
        ld = '0;
        for (int k = 0; k < STAGES; k++) ld[k] = out_ready | (((~v_q) >> k) != '0);
    end

    // each stage takes its input from the decoder or from the stage before it
    always_comb begin
        nv         = STAGES'({v_q, in_valid});
        instr_d[0] = in_instr;
        imm_d[0]   = dec_imm;
        fmt_d[0]   = dec_fmt;
        for (int k = 1; k < STAGES; k++) begin
            instr_d[k] = instr_q[k-1];
            imm_d[k]   = imm_q[k-1];
            fmt_d[k]   = fmt_q[k-1];
        end
    end

    // advance the pipeline; payload only changes when a valid word arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                instr_q[k] <= '0;
                imm_q[k]   <= '0;
                fmt_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    v_q[k] <= nv[k];
                    if (nv[k]) begin
                        instr_q[k] <= instr_d[k];
                        imm_q[k]   <= imm_d[k];
                        fmt_q[k]   <= fmt_d[k];
                    end
                end
            end
        end
    end

    assign in_ready  = ld[0] & ~rst;
    assign out_valid = v_q[STAGES-1];
    assign out_imm   = imm_q[STAGES-1];
    assign out_fmt   = fmt_q[STAGES-1];
    assign out_instr = instr_q[STAGES-1];

`ifdef IMMGEN_STATS_EN
    logic [15:0] ill_cnt_q;

    // count accepted illegal words, saturating at all-ones
    always_ff @(posedge clk) begin
        if (rst) ill_cnt_q <= '0;
        else if (in_valid && in_ready && dec_fmt == F_ILL && ill_cnt_q != 16'hFFFF) ill_cnt_q <= ill_cnt_q + 16'd1;
    end

    assign stat_ill_cnt = ill_cnt_q;
`endif
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed vectors against three configurations (32b/1 stage, 32b/3 stages, 64b/2 stages).
module tb_imm_gen_pipe;
    logic        clk = 0;
    logic        rst = 1;
    logic [2:0]  iv = '0, ir, ov, ordy = 3'b111;
    logic [31:0] ii [3];
    logic [2:0]  ofmt [3];
    logic [31:0] oinstr [3];
    logic [63:0] oimm [3];
    logic [31:0] oimm_a, oimm_b;
    logic [63:0] oimm_c;
`ifdef IMMGEN_STATS_EN
    logic [15:0] stat [3];
`endif
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    assign oimm[0] = {32'h0, oimm_a};
    assign oimm[1] = {32'h0, oimm_b};
    assign oimm[2] = oimm_c;

    imm_gen_pipe #(.XLEN(32), .STAGES(1)) d0 (
`ifdef IMMGEN_STATS_EN
        .stat_ill_cnt(stat[0]),
`endif
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_instr(ii[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_imm(oimm_a), .out_fmt(ofmt[0]), .out_instr(oinstr[0]));
    imm_gen_pipe #(.XLEN(32), .STAGES(3)) d1 (
`ifdef IMMGEN_STATS_EN
        .stat_ill_cnt(stat[1]),
`endif
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_instr(ii[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_imm(oimm_b), .out_fmt(ofmt[1]), .out_instr(oinstr[1]));
    imm_gen_pipe #(.XLEN(64), .STAGES(2)) d2 (
`ifdef IMMGEN_STATS_EN
        .stat_ill_cnt(stat[2]),
`endif
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_instr(ii[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_imm(oimm_c), .out_fmt(ofmt[2]), .out_instr(oinstr[2]));

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  f32;
        logic [63:0] i32;
        logic [2:0]  f64;
        logic [63:0] i64;
    } vec_t;

    vec_t tv [17];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic xfer(input int d, input logic [31:0] w, output int lat);
        iv[d] = 1;
        ii[d] = w;
        @(posedge clk); #1;
        iv[d] = 0;
        lat = 0;
        while (!ov[d] && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    function automatic logic [31:0] wk(input int k);
        return (32'(k + 1) << 20) | 32'h13;
    endfunction

    initial begin
        int lat, acc, n;
        logic [63:0] h_imm;
        logic [31:0] h_ins;
        logic [31:0] bb [4];
        logic [2:0]  bf [4];
        logic [63:0] bi [4];
        tv[0]  = '{32'h004A0493, 3'd1, 64'h4,        3'd1, 64'h4};
        tv[1]  = '{32'hFE9A2E23, 3'd2, 64'hFFFFFFFC, 3'd2, 64'hFFFFFFFFFFFFFFFC};
        tv[2]  = '{32'hFF5A0CE3, 3'd3, 64'hFFFFFFF8, 3'd3, 64'hFFFFFFFFFFFFFFF8};
        tv[3]  = '{32'h12345A37, 3'd4, 64'h12345000, 3'd4, 64'h12345000};
        tv[4]  = '{32'h01C000EF, 3'd5, 64'h1C,       3'd5, 64'h1C};
        tv[5]  = '{32'h80000537, 3'd4, 64'h80000000, 3'd4, 64'hFFFFFFFF80000000};
        tv[6]  = '{32'h02801013, 3'd1, 64'h8,        3'd1, 64'd40};
        tv[7]  = '{32'h0000003B, 3'd7, 64'h0,        3'd0, 64'h0};
        tv[8]  = '{32'h00B50533, 3'd0, 64'h0,        3'd0, 64'h0};
        tv[9]  = '{32'h4050D093, 3'd1, 64'h5,        3'd1, 64'h5};
        tv[10] = '{32'hFFF00093, 3'd1, 64'hFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF};
        tv[11] = '{32'hFFF0809B, 3'd7, 64'h0,        3'd1, 64'hFFFFFFFFFFFFFFFF};
        tv[12] = '{32'h0230109B, 3'd7, 64'h0,        3'd1, 64'h3};
        tv[13] = '{32'h800080E7, 3'd1, 64'hFFFFF800, 3'd1, 64'hFFFFFFFFFFFFF800};
        tv[14] = '{32'h7FF12083, 3'd1, 64'h7FF,      3'd1, 64'h7FF};
        tv[15] = '{32'h0000007F, 3'd7, 64'h0,        3'd7, 64'h0};
        tv[16] = '{32'hFFFFF097, 3'd4, 64'hFFFFF000, 3'd4, 64'hFFFFFFFFFFFFF000};
        for (int d = 0; d < 3; d++) ii[d] = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst in_ready", 64'(ir), 64'h0);
        chk("rst out_valid", 64'(ov), 64'h0);
        chk("rst imm d2", oimm[2], 64'h0);
        chk("rst fmt d0", 64'(ofmt[0]), 64'h0);
        chk("rst instr d1", 64'(oinstr[1]), 64'h0);
        rst = 0;
        #1;
        chk("idle in_ready", 64'(ir), 64'h7);

        for (int i = 0; i < 17; i++) begin
            xfer(0, tv[i].instr, lat);
            chk($sformatf("v%0d d0 lat", i), 64'(lat), 64'd0);
            chk($sformatf("v%0d d0 fmt", i), 64'(ofmt[0]), 64'(tv[i].f32));
            chk($sformatf("v%0d d0 imm", i), oimm[0], tv[i].i32);
            chk($sformatf("v%0d d0 instr", i), 64'(oinstr[0]), 64'(tv[i].instr));
            xfer(2, tv[i].instr, lat);
            chk($sformatf("v%0d d2 lat", i), 64'(lat), 64'd1);
            chk($sformatf("v%0d d2 fmt", i), 64'(ofmt[2]), 64'(tv[i].f64));
            chk($sformatf("v%0d d2 imm", i), oimm[2], tv[i].i64);
        end

        bb = '{32'hFE9A2E23, 32'hFF5A0CE3, 32'h12345A37, 32'h01C000EF};
        bf = '{3'd2, 3'd3, 3'd4, 3'd5};
        bi = '{64'hFFFFFFFC, 64'hFFFFFFF8, 64'h12345000, 64'h1C};
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            iv[0] = 1;
            ii[0] = bb[i];
            #1;
            chk($sformatf("bb%0d ready", i), 64'(ir[0]), 64'h1);
            @(posedge clk); #1;
            chk($sformatf("bb%0d valid", i), 64'(ov[0]), 64'h1);
            chk($sformatf("bb%0d fmt", i), 64'(ofmt[0]), 64'(bf[i]));
            chk($sformatf("bb%0d imm", i), oimm[0], bi[i]);
        end
        iv[0] = 0;

        ordy[1] = 0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            iv[1] = 1;
            ii[1] = wk(acc);
            #1;
            if (ir[1]) acc++;
            @(posedge clk); #1;
        end
        iv[1] = 0;
        chk("bp accepted", 64'(acc), 64'd3);
        chk("bp in_ready", 64'(ir[1]), 64'h0);
        chk("bp out_valid", 64'(ov[1]), 64'h1);
        chk("bp head imm", oimm[1], 64'h1);
        h_imm = oimm[1];
        h_ins = oinstr[1];
        repeat (3) @(posedge clk);
        #1;
        chk("bp hold valid", 64'(ov[1]), 64'h1);
        chk("bp hold imm", oimm[1], h_imm);
        chk("bp hold instr", 64'(oinstr[1]), 64'(h_ins));
        ordy[1] = 1;
        n = 0;
        for (int c = 0; c < 20 && n < 5; c++) begin
            iv[1] = acc < 5;
            ii[1] = wk(acc);
            #1;
            if (ov[1]) begin
                chk($sformatf("drain%0d imm", n), oimm[1], 64'(n + 1));
                n++;
            end
            if (iv[1] && ir[1]) acc++;
            @(posedge clk); #1;
        end
        iv[1] = 0;
        chk("drain count", 64'(n), 64'd5);
        chk("drain empty", 64'(ov[1]), 64'h0);

        ordy[1] = 0;
        for (int i = 0; i < 3; i++) begin
            iv[1] = 1;
            ii[1] = wk(i + 5);
            @(posedge clk); #1;
        end
        iv[1] = 0;
        chk("full valid", 64'(ov[1]), 64'h1);
        chk("full ready", 64'(ir[1]), 64'h0);
        rst = 1;
        #1;
        chk("mid rst in_ready", 64'(ir[0]), 64'h0);
        @(posedge clk); #1;
        rst = 0;
        chk("mid rst valid", 64'(ov[1]), 64'h0);
        chk("mid rst imm", oimm[1], 64'h0);
        chk("mid rst fmt", 64'(ofmt[1]), 64'h0);
        chk("mid rst instr", 64'(oinstr[1]), 64'h0);
        ordy[1] = 1;
        xfer(1, 32'hFFF00093, lat);
        chk("post rst lat", 64'(lat), 64'd2);
        chk("post rst imm", oimm[1], 64'hFFFFFFFF);
        chk("post rst fmt", 64'(ofmt[1]), 64'h1);
        @(posedge clk); #1;
        chk("post rst drain", 64'(ov[1]), 64'h0);

`ifdef IMMGEN_STATS_EN
        chk("stat cleared", 64'(stat[0]), 64'h0);
        xfer(0, 32'h0000007F, lat);
        xfer(0, 32'h004A0493, lat);
        xfer(0, 32'h0000FFFF, lat);
        xfer(0, 32'h12345A37, lat);
        xfer(0, 32'h1234567F, lat);
        chk("stat three", 64'(stat[0]), 64'd3);
        chk("stat d2 idle", 64'(stat[2]), 64'd0);
        iv[0] = 1;
        ii[0] = 32'h0000007F;
        repeat (65540) @(posedge clk);
        #1;
        iv[0] = 0;
        chk("stat saturate", 64'(stat[0]), 64'hFFFF);
        repeat (2) @(posedge clk);
        #1;
        chk("stat hold", 64'(stat[0]), 64'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
